// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward-select for one E-stage source register; M has priority over W, x0 never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_we_m,
  input  logic       i_we_w,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_we_m && (i_rd_m != '0) && (i_rd_m == i_rs))
      o_sel = FWD_MEM;
    else if (i_we_w && (i_rd_w != '0) && (i_rd_w == i_rs))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use bubble, branch flush, memory-wait freeze.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1D,
  input  logic [4:0]  RS2D,
  input  logic [4:0]  RS1E,
  input  logic [4:0]  RS2E,
  input  logic [4:0]  RDE,
  input  logic [4:0]  RDM,
  input  logic [4:0]  RDW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_err,
  output logic [1:0]  state
`ifdef HAZARD_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt_tot
`endif
);

  localparam int unsigned     CW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO = CW'(MEM_TIMEOUT);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wait, w_wait_nxt;
  logic          r_err, w_err_set;
  logic          w_lu, w_mw;
  logic          w_stall_fd, w_stall_em, w_flush_d, w_flush_e;
  logic [1:0]    w_fwd_a, w_fwd_b;

  hazard_fwd_sel u_fwd_a (
    .i_rs   (RS1E),
    .i_rd_m (RDM),
    .i_rd_w (RDW),
    .i_we_m (RegWriteM),
    .i_we_w (RegWriteW),
    .o_sel  (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs   (RS2E),
    .i_rd_m (RDM),
    .i_rd_w (RDW),
    .i_we_m (RegWriteM),
    .i_we_w (RegWriteW),
    .o_sel  (w_fwd_b)
  );

  assign w_lu = ResultSrcE && (RDE != '0) && ((RDE == RS1D) || (RDE == RS2D));
  assign w_mw = mem_req && !mem_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_err_set   = 1'b0;
    w_stall_fd  = 1'b0;
    w_stall_em  = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    case (r_state)
      MEM_WAIT: begin
        // E is frozen here, so a pending branch is simply acted on after release
        if (mem_ready) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else if (r_wait == TMO) begin
          w_err_set   = 1'b1;
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          w_stall_fd = 1'b1;
          w_stall_em = 1'b1;
          w_wait_nxt = r_wait + CW'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
        if (w_mw) begin
          w_stall_fd  = 1'b1;
          w_stall_em  = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = CW'(1);
        end else if (PCSrcE) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lu && (r_state == RUN)) begin
          w_stall_fd  = 1'b1;
          w_flush_e   = 1'b1;
          w_state_nxt = LOAD_STALL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign StallF    = rst & w_stall_fd;
  assign StallD    = rst & w_stall_fd;
  assign StallE    = rst & w_stall_em;
  assign StallM    = rst & w_stall_em;
  assign FlushD    = rst & w_flush_d;
  assign FlushE    = rst & w_flush_e;
  assign ForwardAE = rst ? w_fwd_a : FWD_RF;
  assign ForwardBE = rst ? w_fwd_b : FWD_RF;
  assign mem_err   = r_err;
  assign state     = r_state;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt, r_wait_tot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_tot  <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_tot  <= '0;
    end else begin
      if (w_stall_fd && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_e && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + 32'd1;
      if ((r_state == MEM_WAIT) && (r_wait_tot != '1)) r_wait_tot <= r_wait_tot + 32'd1;
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;
  assign wait_cnt_tot = r_wait_tot;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mem_req, mem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
  logic [1:0] ForwardAE, ForwardBE, state;
`ifdef HAZARD_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt_tot;
  logic [31:0] m_stalls, m_flushes, m_waits;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Model: 0 = normal flow, 1 = bubble just inserted, 2 = frozen on memory
  int m_mode   = 0;
  int m_waited = 0;
  bit m_err    = 1'b0;
  logic seen_stall;

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .RDM(RDM), .RDW(RDW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .state(state)
`ifdef HAZARD_PERF_EN
    ,
    .perf_clr(perf_clr), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .wait_cnt_tot(wait_cnt_tot)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RDM != 0 && RDM == rs) return 2'b10;
    if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input bit en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Entered just after a falling edge with inputs already driven; leaves at the next falling edge.
  task automatic step_check(input string tag);
    logic [1:0] ea, eb, est;
    logic [5:0] ectl;
    logic       eerr;
    int         nmode, nwait;
    bit         nerr;
    #1;
    ea = fwd(RS1E); eb = fwd(RS2E);
    ectl = 6'b0; est = 2'(m_mode); eerr = m_err;
    nmode = 0; nwait = 0; nerr = m_err;
    if (!rst) begin
      ea = 0; eb = 0; est = 0; eerr = 0; nerr = 0;
    end else if (m_mode == 2) begin
      if (!mem_ready && m_waited < TMO) begin
        ectl = 6'b111100; nmode = 2; nwait = m_waited + 1;
      end else if (!mem_ready) begin
        nerr = 1'b1;
      end
    end else if (mem_req && !mem_ready) begin
      ectl = 6'b111100; nmode = 2; nwait = 1;
    end else if (PCSrcE) begin
      ectl = 6'b000011;
    end else if (m_mode == 0 && ResultSrcE && RDE != 0 && (RDE == RS1D || RDE == RS2D)) begin
      ectl = 6'b110001; nmode = 1;
    end
    check_eq({tag, ".fwdA"}, 32'(ForwardAE), 32'(ea));
    check_eq({tag, ".fwdB"}, 32'(ForwardBE), 32'(eb));
    check_eq({tag, ".ctl"}, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'(ectl));
    check_eq({tag, ".state"}, 32'(state), 32'(est));
    check_eq({tag, ".err"}, 32'(mem_err), 32'(eerr));
    seen_stall = StallF;
`ifdef HAZARD_PERF_EN
    if (!rst) begin
      m_stalls = 0; m_flushes = 0; m_waits = 0;
    end
    check_eq({tag, ".pstall"}, stall_cnt, m_stalls);
    check_eq({tag, ".pflush"}, flush_cnt, m_flushes);
    check_eq({tag, ".pwait"}, wait_cnt_tot, m_waits);
    if (rst) begin
      if (perf_clr) begin
        m_stalls = 0; m_flushes = 0; m_waits = 0;
      end else begin
        m_stalls  = sat_inc(m_stalls, ectl[4]);
        m_flushes = sat_inc(m_flushes, ectl[0]);
        m_waits   = sat_inc(m_waits, m_mode == 2);
      end
    end
`endif
    @(posedge clk);
    if (rst) begin
      m_mode = nmode; m_waited = nwait; m_err = nerr;
    end else begin
      m_mode = 0; m_waited = 0; m_err = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0; RDE = 0; RDM = 0; RDW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    mem_req = 0; mem_ready = 0;
`ifdef HAZARD_PERF_EN
    perf_clr = 0;
`endif
  endtask

  initial begin
    int nst;
    idle_inputs();
`ifdef HAZARD_PERF_EN
    m_stalls = 0; m_flushes = 0; m_waits = 0;
`endif
    rst = 1'b0;
    // Reset: hazard-provoking inputs must not leak through
    RS1E = 5; RDM = 5; RegWriteM = 1; mem_req = 1; mem_ready = 0;
    @(negedge clk);
    step_check("reset");
    check_eq("reset.fwdA0", 32'(ForwardAE), 32'd0);
    rst = 1'b1;
    idle_inputs();
    step_check("idle");

    // Forwarding priority and x0 exclusion
    RS1E = 5; RDM = 5; RegWriteM = 1; RDW = 5; RegWriteW = 1;
    #1 check_eq("fwd_mem", 32'(ForwardAE), 32'd2);
    step_check("fwd1");
    RDM = 0;
    #1 check_eq("fwd_wb", 32'(ForwardAE), 32'd1);
    step_check("fwd2");
    RS1E = 0;
    #1 check_eq("fwd_x0", 32'(ForwardAE), 32'd0);
    step_check("fwd3");
    idle_inputs();

    // Load-use: one bubble, inputs held so the second cycle shows lu being ignored
    ResultSrcE = 1; RDE = 7; RS2D = 7;
    #1 check_eq("lu_ctl", 32'({StallF, StallD, FlushE, FlushD}), 32'b1110);
    step_check("lu1");
    check_eq("lu_state", 32'(state), 32'd1);
    step_check("lu2");
    ResultSrcE = 0;
    check_eq("lu_back", 32'(state), 32'd0);
    step_check("lu3");

    // Branch overrides load-use
    ResultSrcE = 1; RDE = 7; RS2D = 7; PCSrcE = 1;
    #1 check_eq("br_ctl", 32'({StallD, FlushD, FlushE}), 32'b011);
    step_check("br");
    check_eq("br_state", 32'(state), 32'd0);
    idle_inputs();

    // Memory wait of 3 cycles
`ifdef HAZARD_PERF_EN
    perf_clr = 1;
    step_check("pclr");
    perf_clr = 0;
`endif
    mem_req = 1; mem_ready = 0; nst = 0;
    for (int i = 0; i < 3; i++) begin
      step_check("mw");
      nst += int'(seen_stall);
    end
    mem_ready = 1;
    step_check("mw_rdy");
    nst += int'(seen_stall);
    check_eq("mw_stalls", 32'(nst), 32'd3);
    idle_inputs();
    step_check("mw_done");
`ifdef HAZARD_PERF_EN
    check_eq("mw_tot", wait_cnt_tot, 32'd3);
`endif

    // Timeout: stalls capped at TMO, sticky error
    mem_req = 1; mem_ready = 0; nst = 0;
    for (int i = 0; i < TMO + 1; i++) begin
      step_check("tmo");
      nst += int'(seen_stall);
    end
    check_eq("tmo_stalls", 32'(nst), 32'(TMO));
    mem_req = 0;
    for (int i = 0; i < 3; i++) step_check("tmo_hold");
    check_eq("tmo_sticky", 32'(mem_err), 32'd1);

    // Reset in the middle of a wait
    mem_req = 1; mem_ready = 0;
    step_check("rw1");
    step_check("rw2");
    rst = 1'b0;
    step_check("rw_rst");
    check_eq("rw_state", 32'(state), 32'd0);
    rst = 1'b1;
    idle_inputs();
    step_check("rw_after");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      RS1D = 5'($urandom_range(0, 3)); RS2D = 5'($urandom_range(0, 3));
      RS1E = 5'($urandom_range(0, 3)); RS2E = 5'($urandom_range(0, 3));
      RDE  = 5'($urandom_range(0, 3)); RDM  = 5'($urandom_range(0, 3));
      RDW  = 5'($urandom_range(0, 3));
      RegWriteM  = ($urandom_range(0, 1) == 1);
      RegWriteW  = ($urandom_range(0, 1) == 1);
      ResultSrcE = ($urandom_range(0, 9) < 3);
      PCSrcE     = ($urandom_range(0, 9) == 0);
      mem_req    = ($urandom_range(0, 19) < 3);
      mem_ready  = ($urandom_range(0, 9) < 4);
      rst        = ($urandom_range(0, 199) != 0);
`ifdef HAZARD_PERF_EN
      perf_clr   = ($urandom_range(0, 49) == 0);
`endif
      step_check("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It drives every stall, flush and forward-select line of the fetch/decode/execute/memory/writeback registers. It resolves data hazards by forwarding, load-use hazards by a one-cycle bubble, and taken branches by flushing D and E. It also freezes the whole pipeline while data memory is not ready, with a timeout guard.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive wait cycles before an error is flagged; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RS1D, RS2D  in  5  source registers of the instruction in D
- RS1E, RS2E  in  5  source registers of the instruction in E
- RDE, RDM, RDW  in  5  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  register-write enables in M/W
- ResultSrcE  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- mem_req  in  1  M-stage data-memory access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- perf_clr  in  1  synchronous clear of performance counters (only with HAZARD_PERF_EN)
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE  out  1  load a bubble into the D/E register
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 from W result, 10 from M ALU result
- mem_err  out  1  sticky memory-timeout flag
- state  out  2  current FSM state, for debug
- stall_cnt, flush_cnt, wait_cnt_tot  out  32  performance counters (only with HAZARD_PERF_EN)

## Operation
Forwarding is combinational. For the A operand (B is identical, using RS2E):
- ForwardAE = 10 if RegWriteM && RDM!=0 && RDM==RS1E.
- Otherwise ForwardAE = 01 if RegWriteW && RDW!=0 && RDW==RS1E.
- Otherwise ForwardAE = 00.
- M has priority over W. Register x0 is never forwarded.

Hazard conditions:
- lu (load-use) = ResultSrcE && RDE!=0 && (RDE==RS1D || RDE==RS2D).
- mw (memory wait) = mem_req && !mem_ready.

FSM states: RUN=00, LOAD_STALL=01, MEM_WAIT=10. Outputs are Mealy (current state plus inputs).
- **RUN**
  - If mw: StallF, StallD, StallE and StallM are all 1, no flush; next state MEM_WAIT, wait counter = 1.
  - Else if PCSrcE: FlushD = FlushE = 1, no stall; next state RUN. A branch overrides lu, because the dependent instruction is flushed.
  - Else if lu: StallF = StallD = 1 and FlushE = 1; next state LOAD_STALL.
  - Else: all outputs 0.
- **LOAD_STALL**
  - lu is ignored (E holds a bubble).
  - mw and PCSrcE are handled exactly as in RUN.
  - Otherwise, next state RUN.
- **MEM_WAIT**
  - While !mem_ready: all four stalls are 1 and the wait counter increments.
  - When mem_ready=1: stalls are 0 in that same cycle; next state RUN.
  - If the counter reaches MEM_TIMEOUT while mem_ready is still 0: set mem_err, release the stalls in that cycle, next state RUN.
  - PCSrcE is masked in MEM_WAIT. E is frozen, so PCSrcE is still asserted after release and is acted on then.
- mem_err stays set until reset.

## Timing
- Reset (rst low, async):
  - state = RUN, wait counter = 0, mem_err = 0.
  - While rst is low, every stall/flush output and both Forward outputs are forced to 0.
- Forward, stall and flush outputs are valid in the same cycle as their inputs (zero latency).
- The state register updates on the rising edge of clk.
- A load-use produces exactly one bubble cycle.
- A taken branch costs 2 flushed slots in one cycle.
- Memory wait freezes the pipeline for N cycles, where N is the number of cycles with mem_ready=0, capped at MEM_TIMEOUT.
- Priority when events coincide: mw > PCSrcE > lu.
- The wait counter width is $clog2(MEM_TIMEOUT+1). It never wraps; it clears on entry to RUN.
- Reset asserted mid-wait immediately returns the FSM to RUN with no stalls.

## Configuration
Macro **HAZARD_PERF_EN**.

When defined, three 32-bit saturating counters exist:
- stall_cnt: cycles with StallD=1.
- flush_cnt: cycles with FlushE=1.
- wait_cnt_tot: cycles spent in MEM_WAIT.

Counter behaviour:
- Reset to 0 asynchronously.
- Cleared synchronously by perf_clr; perf_clr takes priority over increment.
- Hold at 0xFFFFFFFF once reached.

When not defined, the counter outputs and perf_clr are absent and no counter logic is synthesized.

## Structure
- Shared package **hazard_pkg** contains:
  - The state enum (RUN, LOAD_STALL, MEM_WAIT).
  - Forward-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, **hazard_fwd_sel**, computes a 2-bit select from one source register, RDM/RDW and RegWriteM/W. It is instantiated twice, for A and B.

## Test plan
- RS1E=5, RDM=5, RegWriteM=1, RDW=5, RegWriteW=1 -> ForwardAE=10. Repeat with RDM=0 -> ForwardAE=01. Repeat with RS1E=0 -> 00.
- Load in E with RDE=7, ResultSrcE=1, RS2D=7 -> one cycle of StallF=StallD=FlushE=1 and state=01, then RUN with all outputs 0.
- PCSrcE=1 together with the load-use from the previous case -> FlushD=FlushE=1, StallD=0, state stays RUN.
- mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> all stalls high for exactly 3 cycles, low in the ready cycle; with HAZARD_PERF_EN, wait_cnt_tot=3.
- MEM_TIMEOUT=4 with mem_ready held 0 -> mem_err rises on the 4th wait cycle, stalls drop, FSM returns to RUN, and mem_err stays 1 until rst.
- rst pulled low during MEM_WAIT -> all stalls 0 immediately, state=00, mem_err=0, counters=0.
